umi_req_arbmux: RTL and testbench
=================================

Name: umi_req_arbmux

Overview:
- N:1 UMI request arbiter plus response router. Sits directly upstream of the single device port of umi_ram or any single-port UMI device.
- Merges N host request channels into one device request channel using round-robin arbitration, through a registered output stage.
- Records which host issued each request that expects a response, in a tag FIFO. Routes each device response back to that host, in order.

Parameters:
- N, 4, number of host ports (2..16)
- CW, 32, UMI command width
- AW, 64, UMI address width
- DW, 256, UMI data width
- TAGDEPTH, 8, outstanding-response tag FIFO depth (power of 2, >=2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- host_req_valid  in  N  per-host request valid
- host_req_cmd  in  N*CW  request cmd, host i at [i*CW+:CW]
- host_req_dstaddr  in  N*AW  request destination address
- host_req_srcaddr  in  N*AW  request source address
- host_req_data  in  N*DW  request data
- host_req_ready  out  N  per-host request ready
- host_resp_valid  out  N  per-host response valid
- host_resp_cmd  out  N*CW  response cmd (device resp_cmd broadcast to all hosts)
- host_resp_dstaddr  out  N*AW  broadcast
- host_resp_srcaddr  out  N*AW  broadcast
- host_resp_data  out  N*DW  broadcast
- host_resp_ready  in  N  per-host response ready
- dev_req_valid, dev_req_cmd, dev_req_dstaddr, dev_req_srcaddr, dev_req_data  out  1/CW/AW/AW/DW  merged request
- dev_req_ready  in  1
- dev_resp_valid, dev_resp_cmd, dev_resp_dstaddr, dev_resp_srcaddr, dev_resp_data  in  1/CW/AW/AW/DW  device response
- dev_resp_ready  out  1
- outstanding  out  $clog2(TAGDEPTH)+1  tag FIFO occupancy

Behaviour:
- Reset is synchronous on clk, active-high, and applies to everything below.
  - dev_req_valid=0, host_resp_valid=0, outstanding=0, RR pointer=0, tag FIFO empty.
  - Payload registers are don't-care.
- Handshakes are valid/ready.
  - Transfer happens when both are high at a rising edge.
  - Valid, once high, must not drop without a transfer; the block honours this on its outputs.
- Expects-response rule:
  - need_resp = 1 when cmd[4:0] is 5'h01 (READ), 5'h03 (WRITE) or 5'h09 (ATOMIC).
  - need_resp = 0 for all other opcodes, e.g. 5'h05 POSTED.
  - Every transaction is a single beat.
- Output stage is a one-entry register.
  - load_ok = !dev_req_valid | dev_req_ready, which allows full throughput.
- Eligibility: host i is eligible when host_req_valid[i] is high, and either need_resp=0 or the tag FIFO is not full.
  - When the FIFO is full, posted requests still pass.
- Arbitration:
  - Round-robin starting at the RR pointer.
  - The winner is the first eligible host at or above the pointer, wrapping to 0.
  - host_req_ready[winner] = load_ok. All other bits are 0.
  - On a grant: the output register loads the winner's fields, and the pointer becomes (winner+1) mod N.
  - If the granted request has need_resp=1, winner index is pushed into the tag FIFO in the same cycle.
- Request latency: host transfer at edge k gives dev_req_valid high from k until the dev handshake. Minimum latency is 1 cycle.
- Response routing:
  - When the tag FIFO is non-empty, head = tag at the read pointer.
  - host_resp_valid[head] = dev_resp_valid. Other bits are 0.
  - dev_resp_ready = host_resp_ready[head].
  - The response path is combinational, with zero latency.
  - On a response handshake, the head is popped.
- Empty FIFO: host_resp_valid = 0 and dev_resp_ready = 0, unless UMI_ARBMUX_ORPHAN_EN is defined (see Optional Feature).
- Simultaneous push and pop:
  - Allowed in one cycle, including when the FIFO is full. A pop frees the slot for the same-cycle push.
  - outstanding is unchanged in that case.
  - Full and empty are derived from pointers carrying one extra wrap bit.
- Ordering: responses must return in request order, which the device guarantees. A single-host stall blocks all later responses.
- Reset mid-operation: reset drops all in-flight state, including tags and the pending output beat. Responses arriving afterwards are treated as arriving at an empty FIFO.

Optional Feature:
- Macro: UMI_ARBMUX_ORPHAN_EN.
- Defined:
  - A response arriving while the FIFO is empty is accepted and dropped (dev_resp_ready=1).
  - Extra output port orphan_err (1 bit) sets and stays high until reset.
- Undefined: no orphan_err port. Responses arriving at an empty FIFO stall (dev_resp_ready=0).

Test Plan:
- Fairness: N=4, all hosts issue POSTED (cmd=5'h05) every cycle, dev_req_ready=1. Device order is 0,1,2,3,0,... with one beat per cycle after the first. outstanding stays 0.
- Routing: host 2 READ to addr 0x100, then host 0 READ to addr 0x200. Device returns two responses in order. The first is valid only on host_resp_valid[2], the second only on [0]. outstanding goes 0→1→2→1→0.
- Tag full: 8 READs from host 1 with no device responses.
  - 9th READ from host 3: host_req_ready[3]=0.
  - A POSTED from host 0 in the same cycle is still granted.
  - After one response pop, host 3 is granted in the next cycle.
- Backpressure:
  - dev_req_ready=0 for 5 cycles: dev_req_valid and the payload are held stable, and all host_req_ready=0.
  - host_resp_ready[head]=0: dev_resp_ready=0 and no pop.
- Simultaneous: FIFO full (8), response pop and a new READ grant in the same edge. outstanding stays 8 and the new tag lands at the tail.
- Reset/orphan: assert reset with 3 outstanding, then inject a response.
  - Without the macro: dev_resp_ready=0.
  - With UMI_ARBMUX_ORPHAN_EN: the response is consumed and orphan_err=1.

Source files
------------

// File: rtl/umi_req_arbmux.sv
// umi_req_arbmux: N:1 round-robin UMI request arbiter with a registered
// output beat and an in-order response router driven by a host-tag FIFO.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   host_req_*        N packed host request channels (host i at [i*W+:W])
//   host_resp_*       N response channels; payload broadcast, valid steered
//   dev_req_*         merged request towards the single device port
//   dev_resp_*        device response channel
//   outstanding       number of tags waiting for a response
//   orphan_err        only with UMI_ARBMUX_ORPHAN_EN: sticky flag raised when
//                     a response arrives with no tag outstanding
//
// Optional build macro: UMI_ARBMUX_ORPHAN_EN (accept and drop orphan responses).

module umi_req_arbmux #(
  parameter int N        = 4,
  parameter int CW       = 32,
  parameter int AW       = 64,
  parameter int DW       = 256,
  parameter int TAGDEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N-1:0]                host_req_valid,
  input  logic [N*CW-1:0]             host_req_cmd,
  input  logic [N*AW-1:0]             host_req_dstaddr,
  input  logic [N*AW-1:0]             host_req_srcaddr,
  input  logic [N*DW-1:0]             host_req_data,
  output logic [N-1:0]                host_req_ready,
  output logic [N-1:0]                host_resp_valid,
  output logic [N*CW-1:0]             host_resp_cmd,
  output logic [N*AW-1:0]             host_resp_dstaddr,
  output logic [N*AW-1:0]             host_resp_srcaddr,
  output logic [N*DW-1:0]             host_resp_data,
  input  logic [N-1:0]                host_resp_ready,
  output logic                        dev_req_valid,
  output logic [CW-1:0]               dev_req_cmd,
  output logic [AW-1:0]               dev_req_dstaddr,
  output logic [AW-1:0]               dev_req_srcaddr,
  output logic [DW-1:0]               dev_req_data,
  input  logic                        dev_req_ready,
  input  logic                        dev_resp_valid,
  input  logic [CW-1:0]               dev_resp_cmd,
  input  logic [AW-1:0]               dev_resp_dstaddr,
  input  logic [AW-1:0]               dev_resp_srcaddr,
  input  logic [DW-1:0]               dev_resp_data,
  output logic                        dev_resp_ready,
  output logic [$clog2(TAGDEPTH):0]   outstanding
`ifdef UMI_ARBMUX_ORPHAN_EN
  ,
  output logic                        orphan_err
`endif
);

  localparam int NW = $clog2(N);
  localparam int TW = $clog2(TAGDEPTH);

  // ------------------------------------------------------------------
  // Round-robin state and tag FIFO storage
  // ------------------------------------------------------------------
  logic [NW-1:0] rr_ptr;
  logic [NW-1:0] tag_mem [TAGDEPTH];
  logic [TW:0]   wptr;
  logic [TW:0]   rptr;

  logic          fifo_full;
  logic          fifo_empty;
  logic [NW-1:0] head;
  logic          push;
  logic          pop;
  logic          tag_room;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[TW] != rptr[TW]) &&
                      (wptr[TW-1:0] == rptr[TW-1:0]);
  assign head       = tag_mem[rptr[TW-1:0]];
  assign outstanding = wptr - rptr;

  // ------------------------------------------------------------------
  // Response routing (combinational, in request order)
  // ------------------------------------------------------------------
  always_comb begin
    host_resp_valid = '0;
    dev_resp_ready  = 1'b0;
    if (!fifo_empty) begin
      host_resp_valid[head] = dev_resp_valid;
      dev_resp_ready        = host_resp_ready[head];
    end else begin
`ifdef UMI_ARBMUX_ORPHAN_EN
      dev_resp_ready = 1'b1;
`else
      dev_resp_ready = 1'b0;
`endif
    end
  end

  assign pop = !fifo_empty && dev_resp_valid && host_resp_ready[head];

  assign host_resp_cmd     = {N{dev_resp_cmd}};
  assign host_resp_dstaddr = {N{dev_resp_dstaddr}};
  assign host_resp_srcaddr = {N{dev_resp_srcaddr}};
  assign host_resp_data    = {N{dev_resp_data}};

  // A pop in this cycle frees a slot for a same-cycle push, so a full FIFO
  // does not block a response-bearing request while a response drains.
  assign tag_room = !fifo_full || pop;

  // ------------------------------------------------------------------
  // Eligibility
  // ------------------------------------------------------------------
  logic [N-1:0] need_resp;
  logic [N-1:0] eligible;

  always_comb begin
    need_resp = '0;
    eligible  = '0;
    for (int i = 0; i < N; i++) begin
      unique case (host_req_cmd[i*CW +: 5])
        5'h01, 5'h03, 5'h09: need_resp[i] = 1'b1;
        default:             need_resp[i] = 1'b0;
      endcase
      eligible[i] = host_req_valid[i] && (!need_resp[i] || tag_room);
    end
  end

  // ------------------------------------------------------------------
  // Round-robin pick: first eligible host at or above rr_ptr, wrapping
  // ------------------------------------------------------------------
  logic          found;
  logic [NW-1:0] winner;
  logic          load_ok;
  logic          grant;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (!found && eligible[j]) begin
        found  = 1'b1;
        winner = NW'(j);
      end
    end
  end

  assign load_ok = !dev_req_valid || dev_req_ready;
  assign grant   = found && load_ok;
  assign push    = grant && need_resp[winner];

  always_comb begin
    host_req_ready = '0;
    if (found) host_req_ready[winner] = load_ok;
  end

  // ------------------------------------------------------------------
  // Control state
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      dev_req_valid <= 1'b0;
      rr_ptr        <= '0;
      wptr          <= '0;
      rptr          <= '0;
    end else begin
      if (grant) begin
        dev_req_valid <= 1'b1;
        rr_ptr <= (winner == NW'(N-1)) ? '0 : winner + 1'b1;
      end else if (dev_req_ready) begin
        dev_req_valid <= 1'b0;
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Payload and tag storage need no reset: qualified by valid / pointers.
  always_ff @(posedge clk) begin
    if (grant) begin
      dev_req_cmd     <= host_req_cmd[winner*CW +: CW];
      dev_req_dstaddr <= host_req_dstaddr[winner*AW +: AW];
      dev_req_srcaddr <= host_req_srcaddr[winner*AW +: AW];
      dev_req_data    <= host_req_data[winner*DW +: DW];
    end
    if (push) tag_mem[wptr[TW-1:0]] <= winner;
  end

`ifdef UMI_ARBMUX_ORPHAN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      orphan_err <= 1'b0;
    end else if (fifo_empty && dev_resp_valid) begin
      orphan_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_umi_req_arbmux.sv
// tb_umi_req_arbmux: directed self-checking bench for umi_req_arbmux.
// Scenario tasks run in sequence from one initial block.

module tb_umi_req_arbmux;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 256;
  localparam int TD = 8;

  logic            clk;
  logic            reset;
  logic [N-1:0]    host_req_valid;
  logic [N*CW-1:0] host_req_cmd;
  logic [N*AW-1:0] host_req_dstaddr;
  logic [N*AW-1:0] host_req_srcaddr;
  logic [N*DW-1:0] host_req_data;
  logic [N-1:0]    host_req_ready;
  logic [N-1:0]    host_resp_valid;
  logic [N*CW-1:0] host_resp_cmd;
  logic [N*AW-1:0] host_resp_dstaddr;
  logic [N*AW-1:0] host_resp_srcaddr;
  logic [N*DW-1:0] host_resp_data;
  logic [N-1:0]    host_resp_ready;
  logic            dev_req_valid;
  logic [CW-1:0]   dev_req_cmd;
  logic [AW-1:0]   dev_req_dstaddr;
  logic [AW-1:0]   dev_req_srcaddr;
  logic [DW-1:0]   dev_req_data;
  logic            dev_req_ready;
  logic            dev_resp_valid;
  logic [CW-1:0]   dev_resp_cmd;
  logic [AW-1:0]   dev_resp_dstaddr;
  logic [AW-1:0]   dev_resp_srcaddr;
  logic [DW-1:0]   dev_resp_data;
  logic            dev_resp_ready;
  logic [3:0]      outstanding;
`ifdef UMI_ARBMUX_ORPHAN_EN
  logic            orphan_err;
`endif

  int n_chk;
  int n_pass;

  umi_req_arbmux #(.N(N), .CW(CW), .AW(AW), .DW(DW), .TAGDEPTH(TD)) dut (
`ifdef UMI_ARBMUX_ORPHAN_EN
    .orphan_err       (orphan_err),
`endif
    .clk              (clk),
    .reset            (reset),
    .host_req_valid   (host_req_valid),
    .host_req_cmd     (host_req_cmd),
    .host_req_dstaddr (host_req_dstaddr),
    .host_req_srcaddr (host_req_srcaddr),
    .host_req_data    (host_req_data),
    .host_req_ready   (host_req_ready),
    .host_resp_valid  (host_resp_valid),
    .host_resp_cmd    (host_resp_cmd),
    .host_resp_dstaddr(host_resp_dstaddr),
    .host_resp_srcaddr(host_resp_srcaddr),
    .host_resp_data   (host_resp_data),
    .host_resp_ready  (host_resp_ready),
    .dev_req_valid    (dev_req_valid),
    .dev_req_cmd      (dev_req_cmd),
    .dev_req_dstaddr  (dev_req_dstaddr),
    .dev_req_srcaddr  (dev_req_srcaddr),
    .dev_req_data     (dev_req_data),
    .dev_req_ready    (dev_req_ready),
    .dev_resp_valid   (dev_resp_valid),
    .dev_resp_cmd     (dev_resp_cmd),
    .dev_resp_dstaddr (dev_resp_dstaddr),
    .dev_resp_srcaddr (dev_resp_srcaddr),
    .dev_resp_data    (dev_resp_data),
    .dev_resp_ready   (dev_resp_ready),
    .outstanding      (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cmd carries the host id in bits [15:8] so the device side can tell who won
  task automatic set_req(input int i, input logic v, input logic [4:0] op,
                         input logic [AW-1:0] dst, input logic [DW-1:0] d);
    host_req_valid[i]          = v;
    host_req_cmd[i*CW +: CW]   = {16'h0, 8'(i), 3'b0, op};
    host_req_dstaddr[i*AW +: AW] = dst;
    host_req_srcaddr[i*AW +: AW] = 64'h5000 + 64'(i);
    host_req_data[i*DW +: DW]  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    host_req_valid   = '0;
    host_req_cmd     = '0;
    host_req_dstaddr = '0;
    host_req_srcaddr = '0;
    host_req_data    = '0;
    host_resp_ready  = '0;
    dev_req_ready    = 1'b1;
    dev_resp_valid   = 1'b0;
    dev_resp_cmd     = '0;
    dev_resp_dstaddr = '0;
    dev_resp_srcaddr = '0;
    dev_resp_data    = '0;
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
    n_chk++;
    if (dev_req_valid !== 1'b0 || host_resp_valid !== 4'b0 ||
        outstanding !== 4'd0)
      $display("FAIL reset_state: dev_req_valid=%b host_resp_valid=%b outstanding=%0d, required 0/0000/0",
               dev_req_valid, host_resp_valid, outstanding);
    else n_pass++;
  endtask

  task automatic test_fairness();
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'h05, 64'h10 * i, 256'(i));
    for (int k = 0; k < 8; k++) begin
      tick();
      n_chk++;
      if (dev_req_valid !== 1'b1 || dev_req_cmd[15:8] !== 8'(k % 4) ||
          outstanding !== 4'd0)
        $display("FAIL fairness_%0d: valid=%b host=%0d outstanding=%0d, required 1/%0d/0",
                 k, dev_req_valid, dev_req_cmd[15:8], outstanding, k % 4);
      else n_pass++;
    end
    @(negedge clk);
    host_req_valid = '0;
    tick();
    n_chk++;
    if (dev_req_valid !== 1'b0)
      $display("FAIL fairness_drain: dev_req_valid=%b, required 0", dev_req_valid);
    else n_pass++;
  endtask

  task automatic test_routing();
    @(negedge clk);
    set_req(2, 1'b1, 5'h01, 64'h100, 256'h22);
    tick();
    n_chk++;
    if (outstanding !== 4'd1 || dev_req_dstaddr !== 64'h100)
      $display("FAIL route_req0: outstanding=%0d dst=%h, required 1/100",
               outstanding, dev_req_dstaddr);
    else n_pass++;
    @(negedge clk);
    host_req_valid = '0;
    set_req(0, 1'b1, 5'h01, 64'h200, 256'h00);
    tick();
    n_chk++;
    if (outstanding !== 4'd2 || dev_req_dstaddr !== 64'h200)
      $display("FAIL route_req1: outstanding=%0d dst=%h, required 2/200",
               outstanding, dev_req_dstaddr);
    else n_pass++;
    @(negedge clk);
    host_req_valid  = '0;
    dev_resp_valid  = 1'b1;
    dev_resp_data   = 256'hABCD;
    host_resp_ready = 4'hF;
    #1;
    n_chk++;
    if (host_resp_valid !== 4'b0100 || dev_resp_ready !== 1'b1 ||
        host_resp_data[2*DW +: DW] !== 256'hABCD)
      $display("FAIL route_resp0: hrv=%b drr=%b data=%h, required 0100/1/abcd",
               host_resp_valid, dev_resp_ready, host_resp_data[2*DW +: 16]);
    else n_pass++;
    tick();
    n_chk++;
    if (outstanding !== 4'd1)
      $display("FAIL route_pop0: outstanding=%0d, required 1", outstanding);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (host_resp_valid !== 4'b0001)
      $display("FAIL route_resp1: hrv=%b, required 0001", host_resp_valid);
    else n_pass++;
    tick();
    n_chk++;
    if (outstanding !== 4'd0)
      $display("FAIL route_pop1: outstanding=%0d, required 0", outstanding);
    else n_pass++;
    @(negedge clk);
    dev_resp_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d1;
    d1 = 256'hDEAD_BEEF;
    @(negedge clk);
    dev_req_ready = 1'b0;
    set_req(1, 1'b1, 5'h05, 64'h300, d1);
    tick();
    @(negedge clk);
    host_req_valid = '0;
    set_req(3, 1'b1, 5'h05, 64'h400, 256'h3333);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_chk++;
      if (dev_req_valid !== 1'b1 || dev_req_data !== d1 ||
          host_req_ready !== 4'b0)
        $display("FAIL bp_hold_%0d: valid=%b data=%h ready=%b, required 1/deadbeef/0000",
                 k, dev_req_valid, dev_req_data[31:0], host_req_ready);
      else n_pass++;
      @(negedge clk);
    end
    dev_req_ready = 1'b1;
    #1;
    n_chk++;
    if (host_req_ready !== 4'b1000)
      $display("FAIL bp_release: ready=%b, required 1000", host_req_ready);
    else n_pass++;
    tick();
    n_chk++;
    if (dev_req_data !== 256'h3333)
      $display("FAIL bp_next: data=%h, required 3333", dev_req_data[31:0]);
    else n_pass++;
    @(negedge clk);
    host_req_valid = '0;
    set_req(2, 1'b1, 5'h03, 64'h500, 256'h0);
    tick();
    @(negedge clk);
    host_req_valid  = '0;
    dev_resp_valid  = 1'b1;
    host_resp_ready = 4'b1011;
    #1;
    n_chk++;
    if (dev_resp_ready !== 1'b0 || host_resp_valid !== 4'b0100)
      $display("FAIL bp_resp_stall: drr=%b hrv=%b, required 0/0100",
               dev_resp_ready, host_resp_valid);
    else n_pass++;
    tick();
    n_chk++;
    if (outstanding !== 4'd1)
      $display("FAIL bp_no_pop: outstanding=%0d, required 1", outstanding);
    else n_pass++;
    @(negedge clk);
    host_resp_ready = 4'hF;
    tick();
    n_chk++;
    if (outstanding !== 4'd0)
      $display("FAIL bp_pop: outstanding=%0d, required 0", outstanding);
    else n_pass++;
    @(negedge clk);
    dev_resp_valid = 1'b0;
  endtask

  task automatic test_tag_full();
    @(negedge clk);
    set_req(1, 1'b1, 5'h01, 64'h600, 256'h0);
    for (int k = 0; k < 8; k++) tick();
    n_chk++;
    if (outstanding !== 4'd8)
      $display("FAIL full_count: outstanding=%0d, required 8", outstanding);
    else n_pass++;
    @(negedge clk);
    host_req_valid = '0;
    set_req(3, 1'b1, 5'h01, 64'h700, 256'h77);
    set_req(0, 1'b1, 5'h05, 64'h800, 256'h88);
    #1;
    n_chk++;
    if (host_req_ready !== 4'b0001)
      $display("FAIL full_block: ready=%b, required 0001", host_req_ready);
    else n_pass++;
    tick();
    n_chk++;
    if (outstanding !== 4'd8 || dev_req_data !== 256'h88)
      $display("FAIL full_posted: outstanding=%0d data=%h, required 8/88",
               outstanding, dev_req_data[31:0]);
    else n_pass++;
    @(negedge clk);
    host_req_valid[0] = 1'b0;
    #1;
    n_chk++;
    if (host_req_ready !== 4'b0000)
      $display("FAIL full_still_blocked: ready=%b, required 0000", host_req_ready);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    dev_resp_valid  = 1'b1;
    host_resp_ready = 4'hF;
    #1;
    n_chk++;
    if (host_req_ready !== 4'b1000 || host_resp_valid !== 4'b0010)
      $display("FAIL simul_comb: ready=%b hrv=%b, required 1000/0010",
               host_req_ready, host_resp_valid);
    else n_pass++;
    tick();
    n_chk++;
    if (outstanding !== 4'd8 || dev_req_dstaddr !== 64'h700)
      $display("FAIL simul_edge: outstanding=%0d dst=%h, required 8/700",
               outstanding, dev_req_dstaddr);
    else n_pass++;
    @(negedge clk);
    host_req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_chk++;
      if (host_resp_valid !== ((k < 7) ? 4'b0010 : 4'b1000))
        $display("FAIL simul_order_%0d: hrv=%b, required %b", k,
                 host_resp_valid, (k < 7) ? 4'b0010 : 4'b1000);
      else n_pass++;
      @(negedge clk);
    end
    n_chk++;
    if (outstanding !== 4'd0)
      $display("FAIL simul_drain: outstanding=%0d, required 0", outstanding);
    else n_pass++;
    dev_resp_valid = 1'b0;
  endtask

  task automatic test_reset_orphan();
    @(negedge clk);
    set_req(2, 1'b1, 5'h09, 64'h900, 256'h0);
    tick();
    tick();
    tick();
    n_chk++;
    if (outstanding !== 4'd3)
      $display("FAIL rst_pre: outstanding=%0d, required 3", outstanding);
    else n_pass++;
    @(negedge clk);
    host_req_valid = '0;
    dev_req_ready  = 1'b0;
    reset          = 1'b1;
    tick();
    @(negedge clk);
    reset = 1'b0;
    n_chk++;
    if (outstanding !== 4'd0 || dev_req_valid !== 1'b0)
      $display("FAIL rst_mid: outstanding=%0d dev_req_valid=%b, required 0/0",
               outstanding, dev_req_valid);
    else n_pass++;
    dev_resp_valid  = 1'b1;
    host_resp_ready = 4'hF;
    #1;
`ifdef UMI_ARBMUX_ORPHAN_EN
    n_chk++;
    if (dev_resp_ready !== 1'b1 || host_resp_valid !== 4'b0)
      $display("FAIL orphan_accept: drr=%b hrv=%b, required 1/0000",
               dev_resp_ready, host_resp_valid);
    else n_pass++;
    tick();
    n_chk++;
    if (orphan_err !== 1'b1)
      $display("FAIL orphan_err: got %b, required 1", orphan_err);
    else n_pass++;
`else
    n_chk++;
    if (dev_resp_ready !== 1'b0 || host_resp_valid !== 4'b0)
      $display("FAIL orphan_stall: drr=%b hrv=%b, required 0/0000",
               dev_resp_ready, host_resp_valid);
    else n_pass++;
    tick();
`endif
    @(negedge clk);
    dev_resp_valid = 1'b0;
    dev_req_ready  = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_fairness();
    test_routing();
    test_backpressure();
    test_tag_full();
    test_simultaneous();
    test_reset_orphan();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
